// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline stall/flush controller: FSM states,
// stage-register control words and the load-use hazard test.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_e;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Control bits a stage register takes when it is loaded with a bubble.
    localparam logic BUBBLE_REG_WRITE  = 1'b0;
    localparam logic BUBBLE_MEM_TO_REG = 1'b0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_hold;
        logic memwb_bubble;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_DEFAULT  = 6'b110000;
    localparam hz_ctrl_t CTRL_RESET    = 6'b001101;
    localparam hz_ctrl_t CTRL_MEMSTALL = 6'b000011;
    localparam hz_ctrl_t CTRL_BRANCH   = 6'b111100;
    localparam hz_ctrl_t CTRL_LOADUSE  = 6'b000100;

    function automatic logic load_use(input logic       mem_read,
                                      input logic [4:0] rd,
                                      input logic [4:0] rs1,
                                      input logic [4:0] rs2,
                                      input logic       uses_rs2);
        return mem_read && (rd != REG_X0) &&
               ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i)
            count_d = '0;
        else if (inc_i && (count_q != {W{1'b1}}))
            count_d = count_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller: load-use bubbles, taken-branch flushes and
// freezes while a data-memory access is outstanding.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rd,
    input  logic             ex_branch_taken,
    input  logic             exmem_mem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             mem_timeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              mem_timeout_q, mem_timeout_d;
    hz_ctrl_t          ctrl;
    logic              loaduse, waiting, flush_evt;
    logic [WAIT_W-1:0] wait_cnt;

    assign loaduse = load_use(idex_mem_read, idex_rd, id_rs1, id_rs2, id_uses_rs2);

    always_comb begin
        ctrl      = CTRL_DEFAULT;
        state_d   = ST_RUN;
        flush_evt = 1'b0;
        // Once waiting, only dmem_ready matters; the request stays frozen in MEM.
        case (state_q)
            ST_MEM_WAIT: waiting = ~dmem_ready;
            default:     waiting = exmem_mem_req & ~dmem_ready;
        endcase
        if (waiting) begin
            ctrl    = CTRL_MEMSTALL;
            state_d = ST_MEM_WAIT;
        end else if (ex_branch_taken) begin
            ctrl      = CTRL_BRANCH;
            flush_evt = 1'b1;
        end else if (loaduse && (state_q != ST_LOAD_STALL)) begin
            ctrl    = CTRL_LOADUSE;
            state_d = ST_LOAD_STALL;
        end
        mem_timeout_d = mem_timeout_q | (waiting & (wait_cnt >= TMO_LAST));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .rst_ni (reset),
        .clr_i  (1'b0),
        .inc_i  (~ctrl.pc_write),
        .count_o(stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .rst_ni (reset),
        .clr_i  (1'b0),
        .inc_i  (flush_evt),
        .count_o(flush_count)
    );

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk    (clk),
        .rst_ni (reset),
        .clr_i  (~waiting),
        .inc_i  (waiting),
        .count_o(wait_cnt)
    );

    assign {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, memwb_bubble} =
        reset ? ctrl : CTRL_RESET;
    assign state_o     = state_q;
    assign mem_timeout = mem_timeout_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, directed wait/timeout/reset
// sequences, then randomized traffic against a behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 8;
    localparam int CMAX        = (1 << CNT_W) - 1;

    localparam logic [5:0] C_DEF = 6'b110000;
    localparam logic [5:0] C_RST = 6'b001101;
    localparam logic [5:0] C_MEM = 6'b000011;
    localparam logic [5:0] C_BR  = 6'b111100;
    localparam logic [5:0] C_LU  = 6'b000100;

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs1, id_rs2, idex_rd;
    logic             id_uses_rs2, idex_mem_read, ex_branch_taken, exmem_mem_req, dmem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, memwb_bubble;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cycles, flush_count;
    logic             mem_timeout;
    logic [5:0]       dctrl;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_uses_rs2    (id_uses_rs2),
        .idex_mem_read  (idex_mem_read),
        .idex_rd        (idex_rd),
        .ex_branch_taken(ex_branch_taken),
        .exmem_mem_req  (exmem_mem_req),
        .dmem_ready     (dmem_ready),
        .pc_write       (pc_write),
        .ifid_write     (ifid_write),
        .ifid_flush     (ifid_flush),
        .idex_flush     (idex_flush),
        .exmem_hold     (exmem_hold),
        .memwb_bubble   (memwb_bubble),
        .state_o        (state_o),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .mem_timeout    (mem_timeout)
    );

    assign dctrl = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_hold, memwb_bubble};

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u, mr;
        logic [4:0] rd;
        logic       br, req, rdy;
        logic [5:0] ctrl;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[20];

    // Behavioural model state: mode 0 run, 1 after bubble, 2 waiting on memory.
    int m_st, m_wait, m_stall, m_flush;
    bit m_tmo;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u,
                          input logic mr, input logic [4:0] rd, input logic br,
                          input logic req, input logic rdy);
        id_rs1 = rs1; id_rs2 = rs2; id_uses_rs2 = u; idex_mem_read = mr;
        idex_rd = rd; ex_branch_taken = br; exmem_mem_req = req; dmem_ready = rdy;
    endtask

    task automatic idle();
        set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, " ctrl"}, 32'(dctrl), 32'(C_RST));
        chk({tag, " state"}, 32'(state_o), 32'd0);
        chk({tag, " stall"}, 32'(stall_cycles), 32'd0);
        chk({tag, " flush"}, 32'(flush_count), 32'd0);
        chk({tag, " tmo"}, 32'(mem_timeout), 32'd0);
    endtask

    task automatic model_reset();
        m_st = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_tmo = 0;
    endtask

    function automatic void model_comb(output logic [5:0] c, output int nst,
                                       output bit brf, output bit waiting);
        bit lu;
        lu = idex_mem_read && (idex_rd != 0) &&
             ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));
        if (m_st == 1) lu = 0;
        waiting = (m_st == 2) ? !dmem_ready : (exmem_mem_req && !dmem_ready);
        brf = 0;
        if (waiting) begin c = C_MEM; nst = 2; end
        else if (ex_branch_taken) begin c = C_BR; nst = 0; brf = 1; end
        else if (lu) begin c = C_LU; nst = 1; end
        else begin c = C_DEF; nst = 0; end
    endfunction

    initial begin
        logic [5:0] ec;
        int         nst;
        bit         brf, wt, rst_now;

        tbl[0]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, 2'd0};
        tbl[1]  = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU,  2'd0};
        tbl[2]  = '{5'd1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_DEF, 2'd1};
        tbl[3]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, 2'd0};
        tbl[4]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, 2'd0};
        tbl[5]  = '{5'd1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_DEF, 2'd0};
        tbl[6]  = '{5'd9, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, C_LU,  2'd0};
        tbl[7]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_BR,  2'd1};
        tbl[8]  = '{5'd3, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, C_BR,  2'd0};
        tbl[9]  = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM, 2'd0};
        tbl[10] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM, 2'd2};
        tbl[11] = '{5'd4, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1, C_LU,  2'd2};
        tbl[12] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, 2'd1};
        tbl[13] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, C_MEM, 2'd0};
        tbl[14] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_BR,  2'd2};
        tbl[15] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, 2'd0};
        tbl[16] = '{5'd6, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0, C_LU,  2'd0};
        tbl[17] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_MEM, 2'd1};
        tbl[18] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_DEF, 2'd2};
        tbl[19] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_DEF, 2'd0};

        // Reset held for three cycles, then released with no hazards.
        reset = 1'b0;
        idle();
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_vals($sformatf("rst%0d", i));
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("release ctrl", 32'(dctrl), 32'(C_DEF));
        chk("release state", 32'(state_o), 32'd0);
        chk("release stall", 32'(stall_cycles), 32'd0);
        next_cycle();

        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].rs1, tbl[i].rs2, tbl[i].u, tbl[i].mr, tbl[i].rd,
                   tbl[i].br, tbl[i].req, tbl[i].rdy);
            @(negedge clk);
            chk($sformatf("tbl%0d ctrl", i), 32'(dctrl), 32'(tbl[i].ctrl));
            chk($sformatf("tbl%0d state", i), 32'(state_o), 32'(tbl[i].st));
            next_cycle();
        end
        idle();
        @(negedge clk);
        chk("tbl stall_cycles", 32'(stall_cycles), 32'd8);
        chk("tbl flush_count", 32'(flush_count), 32'd3);
        chk("tbl mem_timeout", 32'(mem_timeout), 32'd0);
        next_cycle();

        // Four-cycle memory wait, then release.
        for (int k = 1; k <= 4; k++) begin
            set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("mw%0d ctrl", k), 32'(dctrl), 32'(C_MEM));
            chk($sformatf("mw%0d state", k), 32'(state_o), (k == 1) ? 32'd0 : 32'd2);
            next_cycle();
        end
        set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("mw release ctrl", 32'(dctrl), 32'(C_DEF));
        chk("mw release state", 32'(state_o), 32'd2);
        next_cycle();
        idle();
        @(negedge clk);
        chk("mw state", 32'(state_o), 32'd0);
        chk("mw stall_cycles", 32'(stall_cycles), 32'd12);
        chk("mw mem_timeout", 32'(mem_timeout), 32'd0);
        next_cycle();

        // Long wait: timeout becomes visible on the 8th cycle spent in MEM_WAIT.
        for (int k = 1; k <= 10; k++) begin
            set_in(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
            @(negedge clk);
            chk($sformatf("tmo%0d ctrl", k), 32'(dctrl), 32'(C_MEM));
            chk($sformatf("tmo%0d flag", k), 32'(mem_timeout), (k >= 9) ? 32'd1 : 32'd0);
            next_cycle();
        end
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midwait");
        next_cycle();
        reset = 1'b1;
        idle();
        @(negedge clk);
        chk("postrst ctrl", 32'(dctrl), 32'(C_DEF));
        chk("postrst state", 32'(state_o), 32'd0);
        chk("postrst tmo", 32'(mem_timeout), 32'd0);
        next_cycle();

        // Reset mid-LOAD_STALL must drop the pending bubble.
        set_in(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals("midls");
        next_cycle();
        reset = 1'b1;
        idle();
        @(negedge clk);
        chk("midls after state", 32'(state_o), 32'd0);
        next_cycle();

        // Randomized traffic against the model, with occasional resets.
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_now = ($urandom_range(399) == 0);
            set_in(5'($urandom_range(3)), 5'($urandom_range(3)), 1'($urandom_range(1)),
                   1'($urandom_range(1)), 5'($urandom_range(3)),
                   ($urandom_range(9) < 2), ($urandom_range(9) < 4), 1'($urandom_range(1)));
            reset = rst_now ? 1'b0 : 1'b1;
            @(negedge clk);
            if (rst_now) begin
                check_reset_vals("rnd rst");
            end else begin
                model_comb(ec, nst, brf, wt);
                chk($sformatf("rnd%0d ctrl", n), 32'(dctrl), 32'(ec));
                chk($sformatf("rnd%0d state", n), 32'(state_o), 32'(m_st));
                chk($sformatf("rnd%0d stall", n), 32'(stall_cycles), 32'(m_stall));
                chk($sformatf("rnd%0d flush", n), 32'(flush_count), 32'(m_flush));
                chk($sformatf("rnd%0d tmo", n), 32'(mem_timeout), 32'(m_tmo));
            end
            next_cycle();
            if (rst_now) begin
                model_reset();
            end else begin
                if (!ec[5] && m_stall < CMAX) m_stall++;
                if (brf && m_flush < CMAX) m_flush++;
                if (wt) begin
                    m_wait++;
                    if (m_wait >= MEM_TIMEOUT) m_tmo = 1;
                end else begin
                    m_wait = 0;
                end
                m_st = nst;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage 64-bit pipeline.
- Sequences the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers and the PC.
- Handles three cases: load-use hazards (1-cycle bubble), taken branches (2-stage flush) and multi-cycle data-memory accesses (freeze until the memory handshake completes).
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
- MEM_TIMEOUT, 255: wait cycles in MEM_WAIT before mem_timeout is set.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs2  in  1  the ID instruction reads rs2.
- idex_mem_read  in  1  the instruction in EX is a load.
- idex_rd  in  5  destination register of the instruction in EX.
- ex_branch_taken  in  1  branch/jump in EX resolved taken this cycle.
- exmem_mem_req  in  1  the instruction in MEM performs a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads a bubble (control bits zeroed).
- exmem_hold  out  1  EX/MEM holds its contents.
- memwb_bubble  out  1  MEM/WB loads a bubble (Reg_Write=0, Mem_to_Reg=0).
- state_o  out  2  current FSM state.
- stall_cycles  out  CNT_W  cycles with pc_write=0.
- flush_count  out  CNT_W  taken-branch flushes.
- mem_timeout  out  1  sticky: a memory wait exceeded MEM_TIMEOUT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN; counters=0; wait counter=0; mem_timeout=0.
  - While reset is low, outputs are forced to: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, exmem_hold=0, memwb_bubble=1.
- States: RUN=0, LOAD_STALL=1, MEM_WAIT=2. Value 3 is illegal and recovers to RUN.
- Hazard terms (combinational):
  - memstall = exmem_mem_req & ~dmem_ready.
  - loaduse = idex_mem_read & idex_rd!=0 & (idex_rd==id_rs1 | (id_uses_rs2 & idex_rd==id_rs2)).
  - A destination of x0 never creates a hazard.
- Default outputs (no hazard): pc_write=1, ifid_write=1, all flushes/holds/bubbles=0.
- RUN, priority memstall > ex_branch_taken > loaduse:
  - memstall: pc_write=0, ifid_write=0, exmem_hold=1, memwb_bubble=1, idex_flush=0 (ID/EX frozen because ifid_write=0 gates its load). Next state MEM_WAIT; wait counter=1.
  - ex_branch_taken: pc_write=1 (target), ifid_flush=1, idex_flush=1; flush_count++. Next state RUN. A simultaneous loaduse is ignored because the ID instruction is squashed.
  - loaduse: pc_write=0, ifid_write=0, idex_flush=1. Next state LOAD_STALL.
- LOAD_STALL: lasts exactly one cycle.
  - Default outputs, with loaduse suppressed.
  - memstall and ex_branch_taken are evaluated as in RUN; the bubble in EX cannot assert a branch.
  - Next state RUN, or MEM_WAIT on memstall.
- MEM_WAIT:
  - While dmem_ready=0: same outputs as the RUN memstall case; wait counter++ (saturating).
  - When the wait counter reaches MEM_TIMEOUT, set mem_timeout (sticky until reset) and stay in MEM_WAIT.
  - When dmem_ready=1: release exmem_hold and memwb_bubble; apply branch/loaduse evaluation exactly as in RUN this cycle; next state per that evaluation (RUN or LOAD_STALL); wait counter=0.
- Counters:
  - stall_cycles increments on every out-of-reset cycle with pc_write=0.
  - Both counters saturate at all-ones.
- Reset asserted mid-MEM_WAIT or mid-LOAD_STALL aborts immediately to reset values; no pending stall survives.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding (RUN/LOAD_STALL/MEM_WAIT);
  - REG_X0 = 5'd0;
  - bubble control constants reused by the ID/EX and MEM/WB registers.
- One natural sub-module, sat_counter (width-parameterised saturating incrementer), instanced three times: stall counter, flush counter, wait counter.

Test Plan:
1. Reset release: reset low 3 cycles then high, no hazards → during reset pc_write=0, ifid_flush=1, memwb_bubble=1; first cycle after release pc_write=1, ifid_write=1, state_o=0, counters 0.
2. Load-use: idex_mem_read=1, idex_rd=5, id_rs2=5, id_uses_rs2=1 → one cycle pc_write=0, idex_flush=1, state_o=1; next cycle pc_write=1, state_o=0; stall_cycles=1. Repeat with idex_rd=0 → no stall.
3. Branch flush: ex_branch_taken=1 together with a load-use match → ifid_flush=1, idex_flush=1, pc_write=1, no stall; flush_count=1.
4. Memory wait: exmem_mem_req=1, dmem_ready low 4 cycles then high → 4 cycles of exmem_hold=1, memwb_bubble=1, pc_write=0, state_o=2; release cycle outputs default; stall_cycles=4.
5. Timeout and mid-wait reset: MEM_TIMEOUT=8, dmem_ready held 0 for 10 cycles → mem_timeout=1 from the 8th wait cycle and stays 1; assert reset → state_o=0, mem_timeout=0, counters 0.
6. Release into hazard: dmem_ready=1 in MEM_WAIT with a load-use present → same cycle idex_flush=1, exmem_hold=0; next state_o=1.
